// File: rtl/csr_desc_pkg.sv
// rtl/csr_desc_pkg.sv - register map, bit positions and descriptor type for the CSR descriptor bank
// Shared by the bank top, the descriptor FIFO and the bench.
package csr_desc_pkg;

    // Descriptor field width; keep equal to the bank's DATA_W.
    localparam int DESC_W = 32;

    // Word addresses of the CSR map.
    typedef enum logic [2:0] {
        REG_CONTROL    = 3'd0,
        REG_STATUS     = 3'd1,
        REG_DESC_ADDR  = 3'd2,
        REG_DESC_LEN   = 3'd3,
        REG_IRQ_STATUS = 3'd4,
        REG_IRQ_MASK   = 3'd5,
        REG_PKT_COUNT  = 3'd6,
        REG_RESERVED   = 3'd7
    } reg_addr_e;

    // CONTROL bits
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    // STATUS bits
    localparam int ST_FULL      = 8;
    localparam int ST_EMPTY     = 9;
    localparam int ST_LEVEL_LSB = 16;
    localparam int ST_LEVEL_W   = 8;

    // IRQ_STATUS / IRQ_MASK bits
    localparam int IRQ_PKT_DONE = 0;
    localparam int IRQ_OVERFLOW = 1;
    localparam int IRQ_STATE    = 2;
    localparam int IRQ_W        = 3;

    typedef struct packed {
        logic [DESC_W-1:0] addr;
        logic [DESC_W-1:0] len;
    } desc_t;

endpackage

// File: rtl/csr_desc_bank_if.sv
// rtl/csr_desc_bank_if.sv - Avalon-MM style CSR bus between host and bank
// Signals: address (word), read/write strobes, writedata, readdata, readdatavalid.
// master: host side driving strobes; slave: the register bank.
interface csr_desc_bank_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/csr_desc_bank_desc_fifo.sv
// rtl/csr_desc_bank_desc_fifo.sv - first-word-fall-through descriptor FIFO with flush and overflow pulse
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push_i, wdata_i write request and data
//   pop_i           consume head (ignored when empty)
//   flush_i         empty the FIFO on the next edge; same-cycle push/pop are discarded
//   rdata_o         head entry, zero while empty
//   full_o, empty_o, level_o  occupancy
//   overflow_o      combinational pulse: push refused because full with no pop
module desc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    assign pop_ok     = pop_i && !empty_o && !flush_i;
    assign push_ok    = push_i && !flush_i && (!full_o || pop_ok);
    assign overflow_o = push_i && !flush_i && full_o && !pop_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/csr_desc_bank.sv
// rtl/csr_desc_bank.sv - CSR bank with descriptor queue, W1C interrupts and packet counter
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   bus                 CSR slave (address/read/write/writedata/readdata/readdatavalid)
//   state               engine FSM state, sampled every cycle into STATUS
//   pkt_done            one-cycle pulse per captured packet
//   desc_valid/ready    FWFT descriptor handshake toward the engine
//   desc_addr/desc_len  head descriptor, zero while empty
//   enable              CONTROL[0]
//   irq                 registered interrupt request
module csr_desc_bank
    import csr_desc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DESC_DEPTH = 4,
    parameter int STATE_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    csr_desc_bank_if.slave     bus,
    input  logic [STATE_W-1:0] state,
    input  logic               pkt_done,
    output logic               desc_valid,
    input  logic               desc_ready,
    output logic [DATA_W-1:0]  desc_addr,
    output logic [DATA_W-1:0]  desc_len,
    output logic               enable,
    output logic               irq
);
    localparam int LVL_W = $clog2(DESC_DEPTH) + 1;

    reg_addr_e reg_sel;

    logic [1:0]         ctrl_q,       ctrl_d;
    logic [DATA_W-1:0]  desc_addr_q,  desc_addr_d;
    logic [DATA_W-1:0]  desc_len_q,   desc_len_d;
    logic [IRQ_W-1:0]   irq_status_q, irq_status_d;
    logic [IRQ_W-1:0]   irq_mask_q,   irq_mask_d;
    logic [DATA_W-1:0]  pkt_count_q,  pkt_count_d;
    logic [STATE_W-1:0] state_q;
    logic               irq_q,        irq_d;
    logic [DATA_W-1:0]  rdata_q,      rdata_d;
    logic               rvalid_q;

    logic wr_ctrl, wr_addr, wr_len, wr_irqs, wr_mask, wr_cnt;
    logic flush;

    desc_t              push_desc;
    desc_t              head_desc;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_overflow;
    logic [DATA_W-1:0]  status_word;

    assign reg_sel = reg_addr_e'(bus.address);

    assign wr_ctrl = bus.write && (reg_sel == REG_CONTROL);
    assign wr_addr = bus.write && (reg_sel == REG_DESC_ADDR);
    assign wr_len  = bus.write && (reg_sel == REG_DESC_LEN);
    assign wr_irqs = bus.write && (reg_sel == REG_IRQ_STATUS);
    assign wr_mask = bus.write && (reg_sel == REG_IRQ_MASK);
    assign wr_cnt  = bus.write && (reg_sel == REG_PKT_COUNT);

    // Flush is a strobe only; it is never stored, so CONTROL[2] reads 0.
    assign flush = wr_ctrl && bus.writedata[CTRL_FLUSH];

    // The push carries the staged address with the length being written now.
    assign push_desc.addr = desc_addr_q;
    assign push_desc.len  = bus.writedata;

    desc_fifo #(
        .WIDTH ($bits(desc_t)),
        .DEPTH (DESC_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (wr_len),
        .pop_i      (desc_ready),
        .flush_i    (flush),
        .wdata_i    (push_desc),
        .rdata_o    (head_desc),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level),
        .overflow_o (fifo_overflow)
    );

    assign desc_valid = !fifo_empty;
    assign desc_addr  = head_desc.addr;
    assign desc_len   = head_desc.len;
    assign enable     = ctrl_q[CTRL_ENABLE];
    assign irq        = irq_q;

    assign bus.readdata      = rdata_q;
    assign bus.readdatavalid = rvalid_q;

    always_comb begin
        status_word = '0;
        status_word[STATE_W-1:0] = state_q;
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        desc_addr_d = desc_addr_q;
        desc_len_d  = desc_len_q;
        irq_mask_d  = irq_mask_q;

        if (wr_ctrl) ctrl_d      = bus.writedata[1:0];
        if (wr_addr) desc_addr_d = bus.writedata;
        if (wr_len)  desc_len_d  = bus.writedata;
        if (wr_mask) irq_mask_d  = bus.writedata[IRQ_W-1:0];

        // Clear first, then OR in hardware sets so a coincident set wins.
        irq_status_d = irq_status_q;
        if (wr_irqs) irq_status_d = irq_status_d & ~bus.writedata[IRQ_W-1:0];
        irq_status_d[IRQ_PKT_DONE] = irq_status_d[IRQ_PKT_DONE] | pkt_done;
        irq_status_d[IRQ_OVERFLOW] = irq_status_d[IRQ_OVERFLOW] | fifo_overflow;
        irq_status_d[IRQ_STATE]    = irq_status_d[IRQ_STATE] | (state != state_q);

        // Clear then count, so clear plus pkt_done lands on 1.
        pkt_count_d = wr_cnt ? '0 : pkt_count_q;
        if (pkt_done) pkt_count_d = pkt_count_d + DATA_W'(1);

        irq_d = (|(irq_status_q & irq_mask_q)) & ctrl_q[CTRL_IRQ_EN];

        // Read mux sees only current register values: a same-cycle write
        // is not visible until the following read.
        rdata_d = rdata_q;
        if (bus.read) begin
            unique case (reg_sel)
                REG_CONTROL:    rdata_d = {{(DATA_W-2){1'b0}}, ctrl_q};
                REG_STATUS:     rdata_d = status_word;
                REG_DESC_ADDR:  rdata_d = desc_addr_q;
                REG_DESC_LEN:   rdata_d = desc_len_q;
                REG_IRQ_STATUS: rdata_d = {{(DATA_W-IRQ_W){1'b0}}, irq_status_q};
                REG_IRQ_MASK:   rdata_d = {{(DATA_W-IRQ_W){1'b0}}, irq_mask_q};
                REG_PKT_COUNT:  rdata_d = pkt_count_q;
                REG_RESERVED:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q       <= '0;
            desc_addr_q  <= '0;
            desc_len_q   <= '0;
            irq_status_q <= '0;
            irq_mask_q   <= '0;
            pkt_count_q  <= '0;
            state_q      <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            desc_addr_q  <= desc_addr_d;
            desc_len_q   <= desc_len_d;
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
            pkt_count_q  <= pkt_count_d;
            state_q      <= state;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= bus.read;
        end
    end
endmodule

// File: tb/tb_csr_desc_bank.sv
// tb/tb_csr_desc_bank.sv - randomized and directed bench for csr_desc_bank against a queue-based model
module tb_csr_desc_bank;
    import csr_desc_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] state;
    logic          pkt_done;
    logic          desc_ready;
    logic          desc_valid;
    logic [DW-1:0] desc_addr;
    logic [DW-1:0] desc_len;
    logic          enable;
    logic          irq;

    always #5 clk = ~clk;

    csr_desc_bank_if #(.DATA_W(DW)) bus ();

    csr_desc_bank #(
        .DATA_W     (DW),
        .DESC_DEPTH (DEPTH),
        .STATE_W    (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .state      (state),
        .pkt_done   (pkt_done),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .enable     (enable),
        .irq        (irq)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: architectural registers plus a plain descriptor queue.
    logic [1:0]    m_ctrl;
    logic [DW-1:0] m_dadr, m_dlen, m_cnt, m_rdata;
    logic [2:0]    m_irqs, m_mask;
    logic [SW-1:0] m_state;
    logic          m_rvalid, m_irq;
    desc_t         m_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [2:0] a);
        logic [DW-1:0] r;
        r = '0;
        case (a)
            3'd0: r = {30'b0, m_ctrl};
            3'd1: begin
                r[SW-1:0] = m_state;
                r[8]      = (m_q.size() == DEPTH);
                r[9]      = (m_q.size() == 0);
                r[23:16]  = 8'(m_q.size());
            end
            3'd2: r = m_dadr;
            3'd3: r = m_dlen;
            3'd4: r = {29'b0, m_irqs};
            3'd5: r = {29'b0, m_mask};
            3'd6: r = m_cnt;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_dadr = '0; m_dlen = '0; m_cnt = '0; m_rdata = '0;
        m_irqs = '0; m_mask = '0; m_state = '0; m_rvalid = 1'b0; m_irq = 1'b0;
        m_q.delete();
    endtask

    // One clock: advance the model with the inputs currently applied, clock, then compare.
    task automatic step();
        logic [DW-1:0] rv;
        logic [2:0]    a;
        logic [DW-1:0] wd;
        bit            wr, flush, pop, ovf, irq_next;
        int            n;
        if (!reset) begin
            model_reset();
        end else begin
            a  = bus.address;
            wd = bus.writedata;
            wr = bus.write;
            rv = m_read(a);
            irq_next = (|(m_irqs & m_mask)) && m_ctrl[1];
            flush = wr && a == 3'd0 && wd[2];
            n   = m_q.size();
            pop = desc_ready && n > 0 && !flush;
            ovf = 0;
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (wr && a == 3'd3) begin
                    if (n < DEPTH || pop) m_q.push_back('{addr: m_dadr, len: wd});
                    else ovf = 1;
                end
            end
            if (wr) begin
                case (a)
                    3'd0: m_ctrl = wd[1:0];
                    3'd2: m_dadr = wd;
                    3'd3: m_dlen = wd;
                    3'd4: m_irqs = m_irqs & ~wd[2:0];
                    3'd5: m_mask = wd[2:0];
                    3'd6: m_cnt  = '0;
                    default: ;
                endcase
            end
            if (pkt_done) begin
                m_irqs[0] = 1'b1;
                m_cnt     = m_cnt + 1;
            end
            if (ovf) m_irqs[1] = 1'b1;
            if (state != m_state) m_irqs[2] = 1'b1;
            m_state  = state;
            m_rvalid = bus.read;
            if (bus.read) m_rdata = rv;
            m_irq = irq_next;
        end
        @(posedge clk);
        #1;
        check_val("readdatavalid", bus.readdatavalid, m_rvalid);
        if (m_rvalid) check_val("readdata", bus.readdata, m_rdata);
        check_val("desc_valid", desc_valid, m_q.size() > 0);
        check_val("desc_addr", desc_addr, m_q.size() > 0 ? m_q[0].addr : '0);
        check_val("desc_len", desc_len, m_q.size() > 0 ? m_q[0].len : '0);
        check_val("enable", enable, m_ctrl[0]);
        check_val("irq", irq, m_irq);
    endtask

    task automatic idle();
        bus.read = 1'b0; bus.write = 1'b0;
        step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
        bus.read = 1'b0; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        step();
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
        step();
        bus.read = 1'b0;
    endtask

    initial begin
        reset = 1'b0; state = '0; pkt_done = 1'b0; desc_ready = 1'b0;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        model_reset();
        @(posedge clk); #1;

        // 1: reset with inputs toggling, then STATUS read
        for (int i = 0; i < 6; i++) begin
            bus.address = 3'($urandom_range(0, 7)); bus.read = 1'($urandom);
            bus.write = 1'($urandom); bus.writedata = $urandom();
            state = SW'($urandom); pkt_done = 1'($urandom); desc_ready = 1'($urandom);
            step();
        end
        check_val("rst_outputs", {bus.readdatavalid, desc_valid, enable, irq}, 4'b0);
        state = '0; pkt_done = 1'b0; desc_ready = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        reset = 1'b1;
        rd(3'd1);
        check_val("t1_status", bus.readdata, 32'h0000_0200);

        // 2: two descriptors, popped in order
        wr(3'd2, 32'h1000); wr(3'd3, 32'd64);
        wr(3'd2, 32'h2000); wr(3'd3, 32'd128);
        check_val("t2_head0", {desc_addr, desc_len}, {32'h1000, 32'd64});
        desc_ready = 1'b1; idle(); desc_ready = 1'b0;
        check_val("t2_head1", {desc_addr, desc_len}, {32'h2000, 32'd128});
        desc_ready = 1'b1; idle(); desc_ready = 1'b0;
        check_val("t2_empty", desc_valid, 1'b0);

        // 3: overflow and its interrupt
        for (int i = 0; i < 5; i++) begin
            wr(3'd2, DW'(32'h100 * (i + 1))); wr(3'd3, DW'(i + 1));
        end
        rd(3'd1); check_val("t3_status", bus.readdata, 32'h0004_0100);
        rd(3'd4); check_val("t3_irqs", bus.readdata, 32'h2);
        wr(3'd0, 32'h3); wr(3'd5, 32'h2); idle();
        check_val("t3_irq_on", irq, 1'b1);
        wr(3'd4, 32'h2); idle();
        check_val("t3_irq_off", irq, 1'b0);

        // 4: push into a full queue with a simultaneous pop
        wr(3'd2, 32'hBEEF);
        desc_ready = 1'b1; wr(3'd3, 32'd99); desc_ready = 1'b0;
        rd(3'd1); check_val("t4_status", bus.readdata, 32'h0004_0100);
        rd(3'd4); check_val("t4_no_ovf", bus.readdata, 32'h0);
        for (int i = 0; i < 3; i++) begin desc_ready = 1'b1; idle(); end
        desc_ready = 1'b0;
        check_val("t4_last", {desc_addr, desc_len}, {32'hBEEF, 32'd99});
        desc_ready = 1'b1; idle(); desc_ready = 1'b0;

        // 5: packet counter and W1C race
        wr(3'd6, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pkt_done = 1'b1; idle(); pkt_done = 1'b0; idle();
        end
        rd(3'd6); check_val("t5_count3", bus.readdata, 32'd3);
        pkt_done = 1'b1; wr(3'd6, 32'h0); pkt_done = 1'b0;
        rd(3'd6); check_val("t5_count1", bus.readdata, 32'd1);
        wr(3'd4, 32'h7);
        pkt_done = 1'b1; wr(3'd4, 32'h1); pkt_done = 1'b0;
        rd(3'd4); check_val("t5_w1c_race", bus.readdata, 32'h1);

        // 6: flush and reset mid-fill
        for (int i = 0; i < 3; i++) begin wr(3'd2, DW'(i)); wr(3'd3, DW'(i + 7)); end
        wr(3'd0, 32'h4);
        check_val("t6_flush", desc_valid, 1'b0);
        rd(3'd0); check_val("t6_ctrl", bus.readdata, 32'h0);
        wr(3'd2, 32'h55); wr(3'd3, 32'h66);
        bus.read = 1'b1; bus.address = 3'd2; reset = 1'b0;
        step();
        bus.read = 1'b0; reset = 1'b1;
        check_val("t6_rst_q", desc_valid, 1'b0);
        check_val("t6_rst_rv", bus.readdatavalid, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.address   = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            bus.read      = ($urandom_range(0, 1) == 0);
            bus.write     = ($urandom_range(0, 9) < 4);
            bus.writedata = $urandom();
            if (bus.address == 3'd0) bus.writedata[2] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) state = SW'($urandom);
            pkt_done   = ($urandom_range(0, 4) == 0);
            desc_ready = ($urandom_range(0, 9) < 3);
            reset      = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
